// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light sensor path.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    HOLD,
    FAULT
  } state_t;

  localparam int unsigned DEB_CYCLES_DEF   = 4;
  localparam int unsigned HOLD_CYCLES_DEF  = 8;
  localparam int unsigned STUCK_CYCLES_DEF = 1000;

  localparam logic [7:0] CAR_CNT_MAX = 8'd255;

  // Counter width for a modulus-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the filtered output
// only follows the synchronized input after DEB_CYCLES consecutive
// disagreeing samples.
module sync_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          filt;
  logic [CW-1:0] deb_cnt;

  // Metastability guard for the asynchronous loop input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that differ from the filtered level; accept
  // the new level on the edge the count would reach DEB_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync_q2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      deb_cnt <= '0;
      filt    <= sync_q2;
    end else begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

  assign dout = filt;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Conditions the cross-road vehicle loop into a clean car-waiting request C,
// stretches it over short gaps, flags a stuck loop and counts arrivals.
module car_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  output logic       C,
  output logic       fault,
  output logic [7:0] car_cnt
);

  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam int unsigned SW = cnt_width(STUCK_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic          f;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stuck_cnt;
  logic          hold_clr;
  logic          stuck_clr;
  logic          cnt_inc;

  sync_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sync_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sensor_raw),
    .dout (f)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and counter control; presence takes priority over expiry.
  always_comb begin
    state_nx  = state;
    hold_clr  = 1'b0;
    stuck_clr = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (f) begin
          state_nx  = PRESENT;
          stuck_clr = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      PRESENT: begin
        if (!f) begin
          state_nx = HOLD;
          hold_clr = 1'b1;
        end else if (stuck_cnt == STUCK_LAST) begin
          state_nx = FAULT;
        end
      end
      HOLD: begin
        if (f) begin
          state_nx  = PRESENT;
          stuck_clr = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = IDLE;
        end
      end
      FAULT: begin
        if (!f) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stuck timer runs only while staying in PRESENT, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_cnt <= '0;
    end else if (stuck_clr) begin
      stuck_cnt <= '0;
    end else if (state == PRESENT && state_nx == PRESENT) begin
      stuck_cnt <= stuck_cnt + SW'(1);
    end
  end

  // Hold timer runs only while staying in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (state == HOLD && state_nx == HOLD) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  // Saturating arrival counter, bumped only on a fresh IDLE->PRESENT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_cnt <= '0;
    end else if (cnt_inc && car_cnt != CAR_CNT_MAX) begin
      car_cnt <= car_cnt + 8'd1;
    end
  end

  // Moore outputs from the registered state.
  always_comb begin
    C     = (state != IDLE);
    fault = (state == FAULT);
  end

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Self-checking bench for car_sensor_conditioner: directed vector table,
// hand-written corner sequences and randomized loop activity, all checked
// against a behavioural reference model every cycle.
module tb_car_sensor_conditioner;
  import traffic_pkg::*;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 1000;

  logic       clk;
  logic       rst_n;
  logic       sensor_raw;
  logic       C;
  logic       fault;
  logic [7:0] car_cnt;

  int n_cmp;
  int n_err;

  car_sensor_conditioner #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_raw(sensor_raw),
    .C         (C),
    .fault     (fault),
    .car_cnt   (car_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Described in terms of the loop's history: a 2-sample delay, a run length
  // of disagreeing samples, and ages of the current occupancy / gap.
  typedef struct {
    bit s1;
    bit s;
    bit f;
    int run;
    bit occupied;
    bit stuck;
    bit in_gap;
    int age;
    int gap_len;
    int cnt;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.s1 = 0; z.s = 0; z.f = 0; z.run = 0;
    z.occupied = 0; z.stuck = 0; z.in_gap = 0;
    z.age = 0; z.gap_len = 0; z.cnt = 0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit raw);
    mdl_t n;
    n = m;
    if (m.stuck) begin
      if (!m.f) begin
        n.occupied = 0;
        n.stuck    = 0;
      end
    end else if (!m.occupied) begin
      if (m.f) begin
        n.occupied = 1;
        n.in_gap   = 0;
        n.age      = 1;
        n.cnt      = (m.cnt < 255) ? m.cnt + 1 : 255;
      end
    end else if (m.in_gap) begin
      if (m.f) begin
        n.in_gap = 0;
        n.age    = 1;
      end else if (m.gap_len + 1 >= HOLD) begin
        n.occupied = 0;
        n.in_gap   = 0;
      end else begin
        n.gap_len = m.gap_len + 1;
      end
    end else begin
      if (!m.f) begin
        n.in_gap  = 1;
        n.gap_len = 0;
      end else if (m.age >= STUCK) begin
        n.stuck = 1;
      end else begin
        n.age = m.age + 1;
      end
    end
    if (m.s != m.f) begin
      n.run = m.run + 1;
      if (n.run >= DEB) begin
        n.f   = m.s;
        n.run = 0;
      end
    end else begin
      n.run = 0;
    end
    n.s  = m.s1;
    n.s1 = raw;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= mdl_zero();
    else        mdl <= mdl_step(mdl, sensor_raw);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    n_cmp++;
    if (C !== mdl.occupied || fault !== mdl.stuck || car_cnt !== 8'(mdl.cnt)) begin
      n_err++;
      $display("FAIL model: got C=%0b fault=%0b cnt=%0d expected C=%0b fault=%0b cnt=%0d (t=%0t)",
               C, fault, car_cnt, mdl.occupied, mdl.stuck, mdl.cnt, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input bit v, input int n);
    sensor_raw = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arrival();
    drive(1'b1, 20);
    drive(1'b0, 30);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit raw;
    int cycles;
    bit exp_c;
    bit exp_fault;
    int exp_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    sensor_raw = 1'b0;

    // Vectors from a fresh reset, applied back to back.
    tbl.push_back('{1'b1,    6, 1'b0, 1'b0, 0}); // still filtering
    tbl.push_back('{1'b1,    1, 1'b1, 1'b0, 1}); // C rises after edge 7
    tbl.push_back('{1'b1,    5, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0,   14, 1'b1, 1'b0, 1}); // held through release + hold
    tbl.push_back('{1'b0,    1, 1'b0, 1'b0, 1}); // C falls after edge 15
    tbl.push_back('{1'b1,    3, 1'b0, 1'b0, 1}); // short pulse ignored
    tbl.push_back('{1'b0,    3, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1,   20, 1'b1, 1'b0, 2}); // second car
    tbl.push_back('{1'b0,    7, 1'b1, 1'b0, 2}); // into HOLD
    tbl.push_back('{1'b1,   10, 1'b1, 1'b0, 2}); // re-rise: same vehicle
    tbl.push_back('{1'b0,    8, 1'b1, 1'b0, 2}); // HOLD, expiry aligned with f rise
    tbl.push_back('{1'b1,    7, 1'b1, 1'b0, 2}); // presence wins at expiry
    tbl.push_back('{1'b1,   10, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0,   14, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0,    1, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b1, 1006, 1'b1, 1'b0, 3}); // third car, not yet stuck
    tbl.push_back('{1'b1,    1, 1'b1, 1'b1, 3}); // stuck 1000 cycles after entry
    tbl.push_back('{1'b1,   93, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b0,    6, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b0,    1, 1'b0, 1'b0, 3}); // cleared once f falls
    tbl.push_back('{1'b0,   10, 1'b0, 1'b0, 3});

    repeat (3) @(negedge clk);
    check("reset_C", int'(C), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_cnt", int'(car_cnt), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].raw, tbl[i].cycles);
      check($sformatf("vec%0d_C", i), int'(C), int'(tbl[i].exp_c));
      check($sformatf("vec%0d_fault", i), int'(fault), int'(tbl[i].exp_fault));
      check($sformatf("vec%0d_cnt", i), int'(car_cnt), tbl[i].exp_cnt);
    end

    // Ten 3-cycle bounces: nothing should move.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3);
      drive(1'b0, 3);
      check("bounce_C", int'(C), 0);
      check("bounce_cnt", int'(car_cnt), 3);
    end

    // Saturation: 300 clean arrivals on top of 3.
    for (int k = 0; k < 300; k++) begin
      arrival();
      if (k == 251) check("sat_reach", int'(car_cnt), 255);
    end
    check("sat_final", int'(car_cnt), 255);
    check("sat_C", int'(C), 0);

    // Asynchronous reset while PRESENT with five cars counted.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) arrival();
    drive(1'b1, 10);
    check("pre_rst_C", int'(C), 1);
    check("pre_rst_cnt", int'(car_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_C", int'(C), 0);
    check("async_rst_cnt", int'(car_cnt), 0);
    check("async_rst_fault", int'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 6);
    check("restart_C_early", int'(C), 0);
    drive(1'b1, 1);
    check("restart_C", int'(C), 1);
    check("restart_cnt", int'(car_cnt), 1);

    // Randomized loop activity: alternating runs of random length.
    for (int k = 0; k < 300; k++) begin
      drive(~sensor_raw, int'($urandom_range(1, 24)));
    end
    drive(1'b0, 20);
    check("rand_idle_C", int'(C), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
